// File: rtl/ifm_pkg.sv
// Shared definitions for the instruction fetch memory.
//   fsm_state_t : INIT (boot image self-load) / RUN (fetch + loader service)
//   BOOT_IMAGE  : program bytes written to addresses 0.. during INIT
//   boot_byte() : boot table lookup, zero beyond the table
package ifm_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    localparam int unsigned BOOT_IMAGE_LEN = 10;

    localparam logic [7:0] BOOT_IMAGE [0:BOOT_IMAGE_LEN-1] = '{
        8'h55, 8'h89, 8'hb8, 8'h02, 8'h00, 8'h00, 8'h00, 8'h5d, 8'hc3, 8'he8
    };

    function automatic logic [7:0] boot_byte(input logic [31:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int unsigned k = 0; k < BOOT_IMAGE_LEN; k++) begin
            if (idx == k) begin
                b = BOOT_IMAGE[k];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ifm_byte_ram.sv
// Byte-wide storage array: one synchronous write port, NumRd asynchronous read ports.
//   clk_i   : write clock
//   we_i    : write enable; waddr_i / wdata_i give the byte written at the rising edge
//   raddr_i : NumRd packed read addresses, port k in bits [k*AddrW +: AddrW]
//   rdata_o : NumRd packed read bytes, port k in bits [k*8 +: 8]
// Contents are not reset; the owner rewrites them after reset.
module ifm_byte_ram #(
    parameter int unsigned AddrW = 8,
    parameter int unsigned NumRd = 4
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AddrW-1:0]       waddr_i,
    input  logic [7:0]             wdata_i,
    input  logic [NumRd*AddrW-1:0] raddr_i,
    output logic [NumRd*8-1:0]     rdata_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [7:0] mem_q [0:Depth-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned k = 0; k < NumRd; k++) begin
            rdata_o[k*8 +: 8] = mem_q[raddr_i[k*AddrW +: AddrW]];
        end
    end

endmodule

// File: rtl/instruction_fetch_memory.sv
// Byte-addressed program store feeding the decoder.
// After reset it writes the boot image (zero-padded) over the whole array, one byte per
// cycle, then serves fetches of FETCH_BYTES big-endian bytes with address wrap-around.
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   ld_en/ld_addr/ld_data : run-time byte loader, has priority over fetches
//   fetch_req/fetch_addr  : fetch request, accepted when fetch_ready is high
//   fetch_ready           : combinational accept indication
//   ope_valid/ope         : registered fetch response, one cycle after the accepting edge
//   init_done             : boot image load complete
module instruction_fetch_memory
    import ifm_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned FETCH_BYTES = 4,
    parameter int unsigned BOOT_LEN    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [7:0]               ld_data,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     ope_valid,
    output logic [8*FETCH_BYTES-1:0] ope,
    output logic                     init_done
);

    fsm_state_t                   state_q;
    logic [ADDR_W-1:0]            cnt_q;
    logic                         init_done_q;
    logic                         pend_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [8*FETCH_BYTES-1:0]     ope_q;
    logic                         ope_valid_q;

    logic                         we;
    logic [ADDR_W-1:0]            waddr;
    logic [7:0]                   wdata;
    logic [FETCH_BYTES*ADDR_W-1:0] raddr;
    logic [FETCH_BYTES*8-1:0]     rdata;
    logic [8*FETCH_BYTES-1:0]     ope_d;
    logic                         fetch_accept;

    assign fetch_ready  = (state_q == RUN) && !ld_en;
    assign fetch_accept = fetch_req && fetch_ready;

    // INIT owns the write port; in RUN it belongs to the loader.
    always_comb begin
        we    = 1'b0;
        waddr = ld_addr;
        wdata = ld_data;
        if (state_q == INIT) begin
            we    = 1'b1;
            waddr = cnt_q;
            wdata = (32'(cnt_q) < BOOT_LEN) ? boot_byte(32'(cnt_q)) : 8'h00;
        end else if (ld_en) begin
            we = 1'b1;
        end
    end

    // Byte k comes from addr+k, wrapping naturally in ADDR_W bits; byte 0 is most significant.
    always_comb begin
        raddr = '0;
        ope_d = '0;
        for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
            raddr[k*ADDR_W +: ADDR_W]        = addr_q + ADDR_W'(k);
            ope_d[8*(FETCH_BYTES-1-k) +: 8] = rdata[k*8 +: 8];
        end
    end

    ifm_byte_ram #(
        .AddrW (ADDR_W),
        .NumRd (FETCH_BYTES)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            ope_q       <= '0;
            ope_valid_q <= 1'b0;
        end else begin
            // Two-stage fetch: capture address on accept, read array on the next edge.
            ope_valid_q <= pend_q;
            if (pend_q) begin
                ope_q <= ope_d;
            end
            pend_q <= fetch_accept;
            if (fetch_accept) begin
                addr_q <= fetch_addr;
            end

            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign ope       = ope_q;
    assign ope_valid = ope_valid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
module tb_instruction_fetch_memory;

    logic        clk;
    logic        reset;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ready;
    logic        ope_valid;
    logic [31:0] ope;
    logic        init_done;

    int checks;
    int errors;
    logic [31:0] exp_q[$];

    instruction_fetch_memory #(
        .ADDR_W      (8),
        .FETCH_BYTES (4),
        .BOOT_LEN    (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .ope_valid   (ope_valid),
        .ope         (ope),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && ope_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got ope %h expected no response", ope);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (ope !== e) begin
                    errors++;
                    $display("FAIL ope_data: got %h expected %h", ope, e);
                end
            end
        end
    end

    // Drive one cycle of a fetch that must be accepted; queue its expected data.
    task automatic issue(input logic [7:0] a, input logic [31:0] e, input string name);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        check({name, "_ready"}, {31'b0, fetch_ready}, 32'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0;
        ld_en     = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Counts rising edges from now until init_done, checking fetch_ready stays low.
    task automatic wait_init(output int cycles, output logic ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (!init_done && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!init_done && fetch_ready) ready_seen = 1'b1;
        end
    endtask

    initial begin
        int          cyc;
        logic        rdy;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        fetch_req  = 1'b0;
        fetch_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ope", ope, 32'h0);
        check("rst_valid", {31'b0, ope_valid}, 32'd0);
        check("rst_ready", {31'b0, fetch_ready}, 32'd0);
        check("rst_init_done", {31'b0, init_done}, 32'd0);

        // T1: init lasts exactly 256 cycles, no fetch accepted meanwhile
        reset     = 1'b0;
        fetch_req = 1'b1;
        wait_init(cyc, rdy);
        check("t1_init_cycles", cyc, 32'd256);
        check("t1_ready_low", {31'b0, rdy}, 32'd0);
        fetch_req = 1'b0;
        @(posedge clk);
        #1;
        check("t1_no_response", exp_q.size(), 32'd0);

        // T2: single fetches
        issue(8'd0, 32'h5589b802, "t2_a0");
        idle();
        drain();
        issue(8'd4, 32'h0000005d, "t2_a4");
        idle();
        drain();

        // T3: back-to-back fetches
        issue(8'd0, 32'h5589b802, "t3_a0");
        issue(8'd4, 32'h0000005d, "t3_a4");
        issue(8'd8, 32'hc3e80000, "t3_a8");
        idle();
        drain();

        // T4: address wrap-around
        issue(8'd254, 32'h00005589, "t4_a254");
        idle();
        drain();

        // T5: loader write collides with a fetch; fetch waits one cycle
        ld_en      = 1'b1;
        ld_addr    = 8'd9;
        ld_data    = 8'h90;
        fetch_req  = 1'b1;
        fetch_addr = 8'd8;
        @(negedge clk);
        check("t5_ready_blocked", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        issue(8'd8, 32'hc3900000, "t5_retry");
        idle();
        drain();

        // T6: reset right after an accepted fetch discards it and reloads the image
        fetch_req  = 1'b1;
        fetch_addr = 8'd0;
        @(negedge clk);
        check("t6_ready", {31'b0, fetch_ready}, 32'd1);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("t6_valid_rst", {31'b0, ope_valid}, 32'd0);
        check("t6_ope_rst", ope, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("t6_valid_hold", {31'b0, ope_valid}, 32'd0);
        check("t6_init_done_rst", {31'b0, init_done}, 32'd0);
        reset = 1'b0;
        wait_init(cyc, rdy);
        check("t6_init_cycles", cyc, 32'd256);
        issue(8'd8, 32'hc3e80000, "t6_a8");
        idle();
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
